// File: rtl/mfcc_feature_reader.sv
//-----------------------------------------------------------------------------
// mfcc_feature_reader
//
// Purpose:
//   Streams the MFCC feature vectors produced by the front end out of the
//   cepstral RAM once the front end signals completion. Each frame holds
//   COEF_PER_FRAME words (13 cepstral, 13 delta, 13 delta-delta). The words
//   are read in address order from 0 to nf*COEF_PER_FRAME-1 and presented on
//   a valid/ready stream. Each word carries end-of-frame and final-frame
//   flags.
//
// Optional feature (macro FEAT_READER_FRAMEHDR_EN):
//   When defined, a single header word {8'hA5, nf} is emitted before the
//   feature words. Both flags are low on the header word. When the macro is
//   undefined, the header state and all of its logic are compiled out.
//
// Ports:
//   clk              in   1   clock; all state changes on the rising edge
//   rst_n            in   1   asynchronous active-low reset
//   fefinish         in   1   front-end complete flag; its rising edge starts a readout
//   framenum         in   8   frame count; sampled on the fefinish rising edge
//   regcep_rdata     in  16   RAM read data, valid one cycle after regcep_rden
//   regcep_rden      out  1   RAM read strobe
//   regcep_rd_addr   out 13   RAM read address
//   feat_data        out 16   streamed word
//   feat_valid       out  1   feat_data is valid
//   feat_ready       in   1   downstream accepts the current word
//   feat_last_coef   out  1   current word is the last coefficient of its frame
//   feat_last_frame  out  1   current word belongs to the final frame
//   busy             out  1   a readout is in progress
//   done             out  1   one-cycle pulse at the end of a readout
//-----------------------------------------------------------------------------
module mfcc_feature_reader #(
    parameter int COEF_PER_FRAME = 39,
    parameter int MAX_FRAMES     = 210
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fefinish,
    input  logic [7:0]  framenum,
    input  logic [15:0] regcep_rdata,
    output logic        regcep_rden,
    output logic [12:0] regcep_rd_addr,
    output logic [15:0] feat_data,
    output logic        feat_valid,
    input  logic        feat_ready,
    output logic        feat_last_coef,
    output logic        feat_last_frame,
    output logic        busy,
    output logic        done
);

    // FSM encoding
    localparam logic [2:0] ST_IDLE  = 3'd0;
`ifdef FEAT_READER_FRAMEHDR_EN
    localparam logic [2:0] ST_HDR   = 3'd1;
`endif
    localparam logic [2:0] ST_READ  = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_FIN   = 3'd4;

    localparam logic [5:0] COEF_LAST = 6'(COEF_PER_FRAME - 1);
    localparam logic [7:0] MAX_NF    = 8'(MAX_FRAMES);

    // FIFO entry layout: {last_frame, last_coef, data[15:0]}
    localparam int ENT_W = 18;

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic [2:0]       state_q,     state_d;
    logic             fefinish_q,  fefinish_d;
    logic [7:0]       nf_q,        nf_d;
    logic [12:0]      addr_q,      addr_d;
    logic [5:0]       coef_q,      coef_d;
    logic [7:0]       frame_q,     frame_d;
    logic             infl_q,      infl_d;
    logic [1:0]       infl_tag_q,  infl_tag_d;
    logic [ENT_W-1:0] ent0_q,      ent0_d;
    logic [ENT_W-1:0] ent1_q,      ent1_d;
    logic [1:0]       occ_q,       occ_d;
    logic             done_q,      done_d;
    logic             busy_q,      busy_d;

    // ---------------------------------------------------------------------
    // Combinational helpers
    // ---------------------------------------------------------------------
    logic             rise_s;
    logic [7:0]       nf_lat_s;
    logic             pop_s;
    logic             push_s;
    logic [ENT_W-1:0] push_ent_s;
    logic [2:0]       fill_s;
    logic             room_s;
    logic             issue_s;
    logic             last_read_s;
    logic             tag_lc_s;
    logic             tag_lf_s;
`ifdef FEAT_READER_FRAMEHDR_EN
    logic             hdr_push_s;
`endif

    assign rise_s   = fefinish & ~fefinish_q;
    assign nf_lat_s = (framenum > MAX_NF) ? MAX_NF : framenum;
    assign pop_s    = (occ_q != 2'd0) & feat_ready;

    // The pop in this same cycle is credited back, so a slot that is leaving
    // counts as free. This lets a 2-entry FIFO sustain one word per cycle
    // while guaranteeing that every returning read finds a slot.
    assign fill_s = {1'b0, occ_q} + {2'b00, infl_q};
    assign room_s = (fill_s < 3'd2) | ((fill_s == 3'd2) & pop_s);

    assign tag_lc_s    = (coef_q == COEF_LAST);
    assign tag_lf_s    = (frame_q == (nf_q - 8'd1));
    assign last_read_s = tag_lc_s & tag_lf_s;

    // Sequencer: start detection, read issue, address/coefficient/frame counters
    always_comb begin
        state_d = state_q;
        nf_d    = nf_q;
        addr_d  = addr_q;
        coef_d  = coef_q;
        frame_d = frame_q;
        issue_s = 1'b0;
`ifdef FEAT_READER_FRAMEHDR_EN
        hdr_push_s = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (rise_s) begin
                    nf_d    = nf_lat_s;
                    addr_d  = 13'd0;
                    coef_d  = 6'd0;
                    frame_d = 8'd0;
`ifdef FEAT_READER_FRAMEHDR_EN
                    // Header is loaded straight into the empty FIFO
                    hdr_push_s = 1'b1;
                    state_d    = ST_HDR;
`else
                    state_d = (nf_lat_s == 8'd0) ? ST_FIN : ST_READ;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
`ifdef FEAT_READER_FRAMEHDR_EN
            ST_HDR: begin
                // Only the header is in the FIFO, so any pop accepts it
                if (pop_s) begin
                    state_d = (nf_q == 8'd0) ? ST_FIN : ST_READ;
                end else begin
                    state_d = ST_HDR;
                end
            end
`endif
            ST_READ: begin
                if (room_s) begin
                    issue_s = 1'b1;
                    addr_d  = addr_q + 13'd1;
                    if (tag_lc_s) begin
                        coef_d  = 6'd0;
                        frame_d = frame_q + 8'd1;
                    end else begin
                        coef_d  = coef_q + 6'd1;
                    end
                    if (last_read_s) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_READ;
                    end
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_DRAIN: begin
                if ((occ_q == 2'd0) && !infl_q) begin
                    state_d = ST_FIN;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Returning read data (or the header word) is the FIFO push source
    always_comb begin
`ifdef FEAT_READER_FRAMEHDR_EN
        if (hdr_push_s) begin
            push_s     = 1'b1;
            push_ent_s = {2'b00, 8'hA5, nf_lat_s};
        end else begin
            push_s     = infl_q;
            push_ent_s = {infl_tag_q, regcep_rdata};
        end
`else
        push_s     = infl_q;
        push_ent_s = {infl_tag_q, regcep_rdata};
`endif
    end

    // Two-entry FIFO; ent0 is the head and drives the stream outputs directly
    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        occ_d  = occ_q;
        case (occ_q)
            2'd0: begin
                if (push_s) begin
                    ent0_d = push_ent_s;
                    occ_d  = 2'd1;
                end else begin
                    occ_d  = 2'd0;
                end
            end
            2'd1: begin
                if (push_s && pop_s) begin
                    ent0_d = push_ent_s;
                    occ_d  = 2'd1;
                end else if (push_s) begin
                    ent1_d = push_ent_s;
                    occ_d  = 2'd2;
                end else if (pop_s) begin
                    occ_d  = 2'd0;
                end else begin
                    occ_d  = 2'd1;
                end
            end
            2'd2: begin
                // Issue control never lets a push arrive here without a pop
                if (pop_s) begin
                    ent0_d = ent1_q;
                    if (push_s) begin
                        ent1_d = push_ent_s;
                        occ_d  = 2'd2;
                    end else begin
                        occ_d  = 2'd1;
                    end
                end else begin
                    occ_d  = 2'd2;
                end
            end
            default: begin
                occ_d = 2'd0;
            end
        endcase
    end

    // Next values for the edge detector, in-flight tag pipe and status flags
    always_comb begin
        fefinish_d = fefinish;
        infl_d     = issue_s;
        infl_tag_d = {tag_lf_s, tag_lc_s};
        done_d     = (state_d == ST_FIN);
        busy_d     = (state_d != ST_IDLE);
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            fefinish_q <= 1'b0;
            nf_q       <= 8'd0;
            addr_q     <= 13'd0;
            coef_q     <= 6'd0;
            frame_q    <= 8'd0;
            infl_q     <= 1'b0;
            infl_tag_q <= 2'b00;
            ent0_q     <= {ENT_W{1'b0}};
            ent1_q     <= {ENT_W{1'b0}};
            occ_q      <= 2'd0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fefinish_q <= fefinish_d;
            nf_q       <= nf_d;
            addr_q     <= addr_d;
            coef_q     <= coef_d;
            frame_q    <= frame_d;
            infl_q     <= infl_d;
            infl_tag_q <= infl_tag_d;
            ent0_q     <= ent0_d;
            ent1_q     <= ent1_d;
            occ_q      <= occ_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    // The strobe is decoded from registered state plus this cycle's pop so
    // that the read-to-valid latency stays at two cycles; it is low in every
    // state other than READ.
    assign regcep_rden     = issue_s;
    assign regcep_rd_addr  = addr_q;
    assign feat_valid      = (occ_q != 2'd0);
    assign feat_data       = ent0_q[15:0];
    assign feat_last_coef  = ent0_q[16];
    assign feat_last_frame = ent0_q[17];
    assign busy            = busy_q;
    assign done            = done_q;

endmodule
